// File: rtl/mprj_wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mprj_wb_pkg
//  Brief    : Shared types and constants for the management-to-user-project
//             Wishbone bridge: FSM state encoding, default error word and
//             the captured request record.
//  Revision : 1.0 - initial release
// ============================================================================
package mprj_wb_pkg;

    // Bridge FSM states; 2-bit explicit encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        GATED = 2'd2,
        RESP  = 2'd3
    } state_e;

    // Word returned to the management core on timeout or gated access
    localparam logic [31:0] c_ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    // Request fields captured from the management bus at launch
    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } req_t;

endpackage : mprj_wb_pkg
`default_nettype wire

// File: rtl/mprj_wb_timer.sv
`default_nettype none
// ============================================================================
//  Module   : mprj_wb_timer
//  Brief    : Per-transaction timeout counter. Counts while enabled, is
//             cleared otherwise, and flags the terminal count
//             (TIMEOUT_CYCLES-1) combinationally so the FSM can abort on the
//             same edge.
//  Revision : 1.0 - initial release
// ============================================================================
module mprj_wb_timer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] c_TERM = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    // Counter: clear has priority; otherwise advance while the request is live
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tc_o = en_i && (cnt_q == c_TERM);

endmodule : mprj_wb_timer
`default_nettype wire

// File: rtl/mprj_wb_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : mprj_wb_bridge
//  Brief    : Registered Wishbone classic bridge from the management core's
//             user-project port to the user area. Retimes each request, gates
//             it with m_wb_iena, and guarantees termination with a timeout
//             that returns ERR_DATA. Optional error counter enabled by
//             defining MPRJ_WB_ERRCNT_EN (adds err_clr_i / err_cnt_o).
//  Revision : 1.0 - initial release
// ============================================================================
module mprj_wb_bridge
    import mprj_wb_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          CNT_W          = 16,
    parameter logic [31:0] ERR_DATA       = c_ERR_DATA_DEFAULT
) (
    input  logic        core_clk,
    input  logic        core_rst,
    input  logic        m_wb_iena,
    input  logic        m_cyc_i,
    input  logic        m_stb_i,
    input  logic        m_we_i,
    input  logic [3:0]  m_sel_i,
    input  logic [31:0] m_adr_i,
    input  logic [31:0] m_dat_i,
    output logic        m_ack_o,
    output logic [31:0] m_dat_o,
    output logic        u_cyc_o,
    output logic        u_stb_o,
    output logic        u_we_o,
    output logic [3:0]  u_sel_o,
    output logic [31:0] u_adr_o,
    output logic [31:0] u_dat_o,
    input  logic        u_ack_i,
    input  logic [31:0] u_dat_i,
    output logic        busy_o,
`ifdef MPRJ_WB_ERRCNT_EN
    input  logic        err_clr_i,
    output logic [7:0]  err_cnt_o,
`endif
    output logic        timeout_o
);

    state_e      state_q;
    req_t        req_q;
    logic        u_cyc_q;
    logic        u_stb_q;
    logic        m_ack_q;
    logic [31:0] m_dat_q;
    logic        busy_q;
    logic        timeout_q;

    logic w_req;
    logic w_tmr_en;
    logic w_tc;
    logic w_gate_hit;
    logic w_timeout;

    assign w_req      = m_cyc_i & m_stb_i;
    assign w_tmr_en   = (state_q == REQ);
    assign w_gate_hit = (state_q == IDLE) & w_req & ~m_wb_iena;
    // Master abort and a real ack both pre-empt the timeout
    assign w_timeout  = w_tmr_en & m_cyc_i & ~u_ack_i & w_tc;

    mprj_wb_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timer (
        .clk   (core_clk),
        .rst   (core_rst),
        .clr_i (~w_tmr_en),
        .en_i  (w_tmr_en),
        .tc_o  (w_tc)
    );

    // Bridge FSM with all outputs registered
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state_q   <= IDLE;
            req_q     <= '0;
            u_cyc_q   <= 1'b0;
            u_stb_q   <= 1'b0;
            m_ack_q   <= 1'b0;
            m_dat_q   <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            m_ack_q   <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (w_req) begin
                        busy_q <= 1'b1;
                        if (m_wb_iena) begin
                            req_q   <= '{we: m_we_i, sel: m_sel_i, adr: m_adr_i, dat: m_dat_i};
                            u_cyc_q <= 1'b1;
                            u_stb_q <= 1'b1;
                            state_q <= REQ;
                        end else begin
                            state_q <= GATED;
                        end
                    end
                end
                REQ: begin
                    // A master that left the cycle must never see an ack, so
                    // the abort is honoured even if the user acks this edge.
                    if (!m_cyc_i) begin
                        u_cyc_q <= 1'b0;
                        u_stb_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (u_ack_i) begin
                        m_dat_q <= u_dat_i;
                        u_cyc_q <= 1'b0;
                        u_stb_q <= 1'b0;
                        m_ack_q <= 1'b1;
                        state_q <= RESP;
                    end else if (w_tc) begin
                        m_dat_q   <= ERR_DATA;
                        u_cyc_q   <= 1'b0;
                        u_stb_q   <= 1'b0;
                        m_ack_q   <= 1'b1;
                        timeout_q <= 1'b1;
                        state_q   <= RESP;
                    end
                end
                GATED: begin
                    m_dat_q <= ERR_DATA;
                    m_ack_q <= 1'b1;
                    state_q <= RESP;
                end
                RESP: begin
                    // Ack is visible during this state; master drops stb now
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign m_ack_o   = m_ack_q;
    assign m_dat_o   = m_dat_q;
    assign u_cyc_o   = u_cyc_q;
    assign u_stb_o   = u_stb_q;
    assign u_we_o    = req_q.we;
    assign u_sel_o   = req_q.sel;
    assign u_adr_o   = req_q.adr;
    assign u_dat_o   = req_q.dat;
    assign busy_o    = busy_q;
    assign timeout_o = timeout_q;

`ifdef MPRJ_WB_ERRCNT_EN
    logic [7:0] err_cnt_q;
    logic       w_err_inc;

    assign w_err_inc = w_gate_hit | w_timeout;

    // Saturating error counter; clear beats a coincident increment
    always_ff @(posedge core_clk) begin
        if (core_rst || err_clr_i) begin
            err_cnt_q <= '0;
        end else if (w_err_inc && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    logic w_unused_err;
    assign w_unused_err = w_gate_hit | w_timeout;
`endif

endmodule : mprj_wb_bridge
`default_nettype wire

// File: tb/tb_mprj_wb_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mprj_wb_bridge
//  Brief    : Self-checking bench for mprj_wb_bridge with TIMEOUT_CYCLES=8.
//             Expected responses are queued when a request is driven and
//             compared when m_ack_o is seen.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mprj_wb_bridge;

    localparam int TO = 8;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        iena   = 1'b1;
    logic        cyc    = 1'b0;
    logic        stb    = 1'b0;
    logic        we     = 1'b0;
    logic [3:0]  sel    = 4'h0;
    logic [31:0] adr    = 32'h0;
    logic [31:0] wdat   = 32'h0;
    logic        u_ack  = 1'b0;
    logic [31:0] u_rdat = 32'h0;
    logic        m_ack;
    logic [31:0] m_dat;
    logic        u_cyc;
    logic        u_stb;
    logic        u_we;
    logic [3:0]  u_sel;
    logic [31:0] u_adr;
    logic [31:0] u_dat;
    logic        busy;
    logic        tmo;
`ifdef MPRJ_WB_ERRCNT_EN
    logic        err_clr = 1'b0;
    logic [7:0]  err_cnt;
`endif

    always #5 clk = ~clk;

    mprj_wb_bridge #(
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (16),
        .ERR_DATA       (32'hDEAD_BEEF)
    ) dut (
        .core_clk  (clk),
        .core_rst  (rst),
        .m_wb_iena (iena),
        .m_cyc_i   (cyc),
        .m_stb_i   (stb),
        .m_we_i    (we),
        .m_sel_i   (sel),
        .m_adr_i   (adr),
        .m_dat_i   (wdat),
        .m_ack_o   (m_ack),
        .m_dat_o   (m_dat),
        .u_cyc_o   (u_cyc),
        .u_stb_o   (u_stb),
        .u_we_o    (u_we),
        .u_sel_o   (u_sel),
        .u_adr_o   (u_adr),
        .u_dat_o   (u_dat),
        .u_ack_i   (u_ack),
        .u_dat_i   (u_rdat),
        .busy_o    (busy),
`ifdef MPRJ_WB_ERRCNT_EN
        .err_clr_i (err_clr),
        .err_cnt_o (err_cnt),
`endif
        .timeout_o (tmo)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Scoreboard of expected responses
    typedef struct {
        logic [31:0] dat;
        logic        to;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb_e;
    int   to_pulses = 0;

    always @(negedge clk) begin
        if (tmo) to_pulses++;
        if (m_ack) begin
            if (sb_q.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                sb_e = sb_q.pop_front();
                check("resp_data", m_dat, sb_e.dat);
                check("resp_timeout", 32'(tmo), 32'(sb_e.to));
            end
        end
    end

    // User-side responder: acks after ack_dly negedges of u_stb (-1 = never)
    int          ack_dly  = -1;
    logic [31:0] ack_word = 32'h0;
    int          stb_seen = 0;

    always @(negedge clk) begin
        if (u_stb && !u_ack) begin
            if (ack_dly >= 0 && stb_seen == ack_dly) begin
                u_ack  = 1'b1;
                u_rdat = ack_word;
            end
            stb_seen++;
        end else begin
            u_ack    = 1'b0;
            stb_seen = 0;
        end
    end

    task automatic xfer(input string tag, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d, input logic gated,
                        input logic [31:0] exp_dat, input logic exp_to,
                        input int exp_lat, input int exp_stb);
        int   lat     = 0;
        int   stb_cyc = 0;
        bit   got     = 1'b0;
        exp_t e;
        e.dat = exp_dat;
        e.to  = exp_to;
        sb_q.push_back(e);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
        @(posedge clk); #1;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (u_stb) stb_cyc++;
            if (lat == 1) begin
                if (gated) begin
                    check({tag, "_ucyc_gated"}, 32'(u_cyc), 32'd0);
                end else begin
                    check({tag, "_uadr"}, u_adr, a);
                    check({tag, "_usel"}, 32'(u_sel), 32'(s));
                    check({tag, "_udat"}, u_dat, d);
                    check({tag, "_uwe"}, 32'(u_we), 32'(w));
                end
            end
            if (m_ack) got = 1'b1;
        end
        check({tag, "_acked"}, 32'(got), 32'd1);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_stb_cycles"}, 32'(stb_cyc), 32'(exp_stb));
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        check({tag, "_ack_one_cycle"}, 32'(m_ack), 32'd0);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_tmo_after"}, 32'(tmo), 32'd0);
    endtask

    // Launch a request and leave it hanging in REQ (user never acks)
    task automatic launch_hang(input logic [31:0] a);
        ack_dly = -1;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
        @(posedge clk); #1;
        @(negedge clk);
        check("hang_launch_ucyc", 32'(u_cyc), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mack", 32'(m_ack), 32'd0);
        check("rst_ucyc", 32'(u_cyc), 32'd0);
        check("rst_ustb", 32'(u_stb), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tmo", 32'(tmo), 32'd0);
        check("rst_mdat", m_dat, 32'd0);
        check("rst_uadr", u_adr, 32'd0);
`ifdef MPRJ_WB_ERRCNT_EN
        check("rst_errcnt", 32'(err_cnt), 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;

        // Read, user acks on the third edge after launch
        ack_dly = 2; ack_word = 32'h1234_5678;
        xfer("rd", 1'b0, 32'h3000_0000, 4'hF, 32'h0, 1'b0, 32'h1234_5678, 1'b0, 4, 3);
        check("rd_no_timeout", 32'(to_pulses), 32'd0);

        // Write, fastest user ack
        ack_dly = 0; ack_word = 32'h0000_0001;
        xfer("wr", 1'b1, 32'h3000_0004, 4'b0011, 32'hA5A5_A5A5, 1'b0, 32'h0000_0001, 1'b0, 2, 1);

        // Gated access
        iena = 1'b0;
        xfer("gate", 1'b0, 32'h3000_000C, 4'hF, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 2, 0);
        iena = 1'b1;
        check("gate_no_timeout", 32'(to_pulses), 32'd0);
`ifdef MPRJ_WB_ERRCNT_EN
        check("errcnt_gate", 32'(err_cnt), 32'd1);
`endif

        // Timeout: no user ack
        ack_dly = -1;
        xfer("to", 1'b0, 32'h3000_0008, 4'hF, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b1, TO + 1, TO);
        check("to_pulse_count", 32'(to_pulses), 32'd1);
`ifdef MPRJ_WB_ERRCNT_EN
        check("errcnt_to", 32'(err_cnt), 32'd2);
`endif

        // User ack on the terminal-count edge: ack wins
        ack_dly = TO - 1; ack_word = 32'hCAFE_F00D;
        xfer("coin", 1'b0, 32'h3000_0010, 4'hF, 32'h0, 1'b0, 32'hCAFE_F00D, 1'b0, TO + 1, TO);
        check("coin_no_timeout", 32'(to_pulses), 32'd1);
`ifdef MPRJ_WB_ERRCNT_EN
        check("errcnt_coin", 32'(err_cnt), 32'd2);
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk);
        check("errcnt_clr", 32'(err_cnt), 32'd0);
`endif

        // Master abort mid-REQ
        launch_hang(32'h3000_0014);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_ucyc", 32'(u_cyc), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_mdat_hold", m_dat, 32'hCAFE_F00D);
        repeat (12) @(negedge clk);
        check("abort_no_timeout", 32'(to_pulses), 32'd1);

        // Reset mid-REQ
        launch_hang(32'h3000_0018);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rstmid_ucyc", 32'(u_cyc), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_mdat", m_dat, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        repeat (4) @(negedge clk);

        // Normal request after recovery
        ack_dly = 1; ack_word = 32'h0BAD_F00D;
        xfer("post", 1'b0, 32'h3000_001C, 4'hF, 32'h0, 1'b0, 32'h0BAD_F00D, 1'b0, 3, 2);

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule : tb_mprj_wb_bridge
`default_nettype wire
